// File: rtl/alu_mult_sequencer_pkg.sv
// alu_mult_sequencer_pkg: MIPSALU control codes and multiply sequencer state encodings
package alu_mult_sequencer_pkg;
  localparam logic [3:0] ALUCTL_AND = 4'h0;
  localparam logic [3:0] ALUCTL_OR  = 4'h1;
  localparam logic [3:0] ALUCTL_ADD = 4'h2;
  localparam logic [3:0] ALUCTL_SUB = 4'h6;
  localparam logic [3:0] ALUCTL_SLT = 4'h7;
  localparam logic [3:0] ALUCTL_NOR = 4'hC;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer: 32x32 unsigned shift-add multiply driven through the shared MIPSALU
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [3:0] ALU_ADD = ALUCTL_ADD,
  parameter logic [3:0] ALU_IDLE = ALUCTL_AND
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);
  logic [1:0] state, nxt;
  logic [WIDTH-1:0] mcand;
  logic [4:0] count;
  logic accept, fire, carry;
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign fire = state == ST_RUN && alu_gnt;
  assign carry = alu_out < hi;
  assign alu_req = busy;
  assign alu_ctl = busy ? ALU_ADD : ALU_IDLE;
  assign alu_a = busy ? hi : '0;
  assign alu_b = busy && lo[0] ? mcand : '0;
  // next state: start wins in IDLE/DONE, RUN leaves only on the 32nd granted add
  always_comb
    nxt = accept ? ST_RUN : state == ST_RUN ? (fire && &count ? ST_DONE : ST_RUN) : ST_IDLE;
  // state, registered status outputs and the hi/lo/mcand datapath
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
      count <= '0;
    end else begin
      state <= nxt;
      busy <= nxt == ST_RUN;
      done <= nxt == ST_DONE;
      if (accept) begin
        mcand <= a;
        lo <= b;
        hi <= '0;
        count <= '0;
      end else if (fire) begin
        hi <= {carry, alu_out[WIDTH-1:1]};
        lo <= {alu_out[0], lo[WIDTH-1:1]};
        count <= count + 5'd1;
      end
    end
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb_alu_mult_sequencer: scoreboard bench with a behavioural MIPSALU and product reference model
module tb_alu_mult_sequencer;
  import alu_mult_sequencer_pkg::*;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, alu_gnt;
  logic [31:0] in_a = '0, in_b = '0;
  logic busy, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_out;
  logic [3:0] alu_ctl;
  int compared = 0, mismatched = 0, gnt_mode = 0, k = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;
  logic hold_prev = 1'b0, done_prev = 1'b0;
  logic [31:0] pa, pb;
  logic [3:0] pc;
  int n, nb;

  alu_mult_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .a(in_a), .b(in_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req),
    .alu_gnt(alu_gnt), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  always #5 clock = ~clock;

  always_comb
    alu_out = alu_ctl == ALUCTL_ADD ? alu_a + alu_b :
              alu_ctl == ALUCTL_OR  ? alu_a | alu_b :
              alu_ctl == ALUCTL_SUB ? alu_a - alu_b :
              alu_ctl == ALUCTL_SLT ? {31'b0, $signed(alu_a) < $signed(alu_b)} :
              alu_ctl == ALUCTL_NOR ? ~(alu_a | alu_b) : alu_a & alu_b;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // grant driver: always high, alternating starting low after a start, or random
  initial begin
    alu_gnt = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      k = start ? 0 : k + 1;
      alu_gnt = gnt_mode == 0 ? 1'b1 : gnt_mode == 1 ? k[0] : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: scoreboard pop on done, idle ALU bus, stall stability
  always @(negedge clock) begin
    if (!reset && done) begin
      check("done_single_pulse", {63'b0, done_prev}, 64'd0);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        mon_exp = sb.pop_front();
        check("result", {hi, lo}, mon_exp);
      end
    end
    if (!busy) begin
      check("idle_alu_ab", {alu_a, alu_b}, 64'd0);
      check("idle_alu_ctl", {59'b0, alu_req, alu_ctl}, {60'b0, ALUCTL_AND});
    end
    if (hold_prev && busy) check("stall_stable", {alu_ctl, alu_a, alu_b[27:0]}, {pc, pa, pb[27:0]});
    if (hold_prev && busy) check("stall_stable_b", {32'b0, alu_b}, {32'b0, pb});
    hold_prev = busy && !alu_gnt && !reset;
    done_prev = done;
    pa = alu_a;
    pb = alu_b;
    pc = alu_ctl;
  end

  task automatic do_start(input logic [31:0] x, input logic [31:0] y, input bit push, input bit now);
    if (!now) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1;
    in_a = x;
    in_b = y;
    if (push) sb.push_back({32'b0, x} * {32'b0, y});
    @(posedge clock);
    #3;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    while (cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (busy) nbusy++;
      if (done) break;
    end
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_regs", {hi, lo}, 64'd0);
    check("reset_flags", {61'b0, busy, done, alu_req}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    // 7 x 6 latency and busy window
    do_start(32'd7, 32'd6, 1, 0);
    wait_done(n, nb);
    check("lat_7x6", 64'(n), 64'd33);
    check("busy_7x6", 64'(nb), 64'd32);
    check("lohi_7x6", {hi, lo}, 64'h0000_0000_0000_002A);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_done(n, nb);
    check("max_operands", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_start(32'h8000_0000, 32'd2, 1, 0);
    wait_done(n, nb);
    check("carry_path", {hi, lo}, 64'h0000_0001_0000_0000);
    // zero multiplier then back-to-back start inside the DONE cycle
    do_start(32'h1234_5678, 32'd0, 1, 0);
    wait_done(n, nb);
    check("lat_zero", 64'(n), 64'd33);
    check("zero_b", {hi, lo}, 64'd0);
    do_start(32'd3, 32'd5, 1, 1);
    wait_done(n, nb);
    check("lat_b2b", 64'(n), 64'd33);
    check("b2b_3x5", {hi, lo}, 64'h0F);
    // alternating grant starting low
    gnt_mode = 1;
    do_start(32'h0000_FFFF, 32'h0001_0001, 1, 0);
    wait_done(n, nb);
    check("lat_toggle", 64'(n), 64'd65);
    check("toggle_result", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    gnt_mode = 0;
    // start during RUN is ignored
    do_start(32'hDEAD_BEEF, 32'h0000_1234, 1, 0);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1;
    in_a = 32'd11;
    in_b = 32'd13;
    @(posedge clock);
    #3;
    start = 1'b0;
    wait_done(n, nb);
    check("ignored_start", {hi, lo}, {32'b0, 32'hDEAD_BEEF} * 64'h1234);
    // reset at RUN cycle 10 aborts without a done pulse
    do_start(32'd1000, 32'd1000, 0, 0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_regs", {hi, lo}, 64'd0);
    check("abort_flags", {61'b0, busy, done, alu_req}, 64'd0);
    repeat (40) @(negedge clock);
    do_start(32'd9, 32'd9, 1, 0);
    wait_done(n, nb);
    check("after_abort_9x9", {hi, lo}, 64'h51);
    // randomized operands under random grant
    gnt_mode = 2;
    for (int i = 0; i < 12; i++) begin
      do_start($urandom, (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom, 1, 0);
      wait_done(n, nb);
      check("rand_min_latency", {63'b0, n >= 33}, 64'd1);
    end
    gnt_mode = 0;
    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle 32x32 unsigned multiply controller (MULTU) producing a 64-bit HI/LO result.
- Has no adder of its own. It sequences the shared MIPSALU through 32 shift-add iterations, using ALU ADD (ALUctl 4'h2).
- Sits beside the execute stage. It requests the ALU with a req/gnt handshake, so the main pipeline keeps priority.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ALU_ADD, 4'h2, ALUctl code driven for an add.
- ALU_IDLE, 4'h0, ALUctl code driven when not requesting (AND).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a multiply; sampled only in IDLE or DONE.
- a  in  32  multiplicand, latched on accepted start.
- b  in  32  multiplier, latched on accepted start.
- busy  out  1  high while an operation is in progress (RUN).
- done  out  1  one-cycle pulse when hi/lo are valid.
- hi  out  32  upper 32 bits of the product.
- lo  out  32  lower 32 bits of the product.
- alu_req  out  1  request for the shared ALU.
- alu_gnt  in  1  grant; the iteration commits only when alu_req and alu_gnt are both high.
- alu_ctl  out  4  ALUctl to MIPSALU.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_out  in  32  ALUOut from MIPSALU (combinational, same cycle).

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. The ports are named clock and reset.
- Reset (also when asserted mid-operation): state=IDLE, hi=0, lo=0, mcand=0, count=0. Outputs are busy=0, done=0, alu_req=0, alu_ctl=ALU_IDLE, alu_a=0, alu_b=0. An aborted multiply leaves no result and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, alu_req=0.
  - On start=1: mcand<=a, lo<=b, hi<=0, count<=0, go to RUN.
- RUN:
  - busy=1, alu_req=1, alu_ctl=ALU_ADD, alu_a=hi, alu_b=(lo[0] ? mcand : 0).
  - carry = (alu_out < hi), unsigned compare done locally.
  - If alu_gnt=1:
    - hi<={carry, alu_out[31:1]};
    - lo<={alu_out[0], lo[31:1]};
    - count<=count+1.
    - If count==31, go to DONE.
  - If alu_gnt=0: all state holds (stall). Outputs stay stable, req stays high, and there is no limit on stall length.
  - start is ignored in RUN; the operands are not re-latched.
- DONE:
  - done=1 for exactly one cycle, busy=0, alu_req=0.
  - Next state is IDLE. If start=1 in DONE, the operands are latched and the next state is RUN (back-to-back operation, no IDLE bubble).
- hi/lo hold their final values from DONE until the next accepted start.
  - On accepted start, hi clears to 0 and lo takes b; consumers must sample the result at the done pulse.
- Latency with alu_gnt held high: start sampled at edge 0, RUN for cycles 1..32, done high in cycle 33. Each gnt-low cycle in RUN adds one cycle.
- alu_ctl/alu_a/alu_b are forced to ALU_IDLE/0/0 whenever alu_req=0, so there is no stray activity on the shared ALU.
- Boundaries:
  - b=0 or a=0 still runs all 32 iterations; there is no early-out.
  - Maximum operands produce the carry path: 0xFFFFFFFF*0xFFFFFFFF.
- All outputs are registered except alu_ctl/alu_a/alu_b, which decode from the state and hi/lo/mcand registers only (no input-to-output combinational path except via alu_out to the carry logic).

Decomposition:
- Shared include/package holds:
  - the MIPSALU control codes (AND 4'h0, OR 4'h1, ADD 4'h2, SUB 4'h6, SLT 4'h7, NOR 4'hC), reused by the ALU control unit and this block;
  - the sequencer state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Single module, no sub-module. The 5-bit iteration counter is inline.
- The bench instantiates MIPSALU plus this block, with alu_out wired back.

Test Plan:
- 7 x 6, gnt tied high: start at cycle 0 → done pulse at cycle 33 with hi=0x00000000, lo=0x0000002A; busy high cycles 1..32.
- 0xFFFFFFFF x 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. 0x80000000 x 2 → hi=0x00000001, lo=0x00000000 (carry path).
- 0x12345678 x 0 → hi=0, lo=0 after 32 RUN cycles. Then a back-to-back start in the DONE cycle with 3 x 5 → second done 33 cycles later, lo=0x0F.
- 0x0000FFFF x 0x00010001 with alu_gnt toggling every cycle (starting low) → done at cycle 65, hi=0, lo=0xFFFFFFFF. alu_a/alu_b/alu_ctl are stable across gnt-low cycles, and alu_ctl=4'h0 outside RUN.
- start pulsed again mid-RUN with different a/b → ignored; the result equals the first operands' product.
- reset asserted at cycle 10 of RUN → next cycle state IDLE, busy=0, hi=lo=0, alu_req=0. No done pulse appears; a fresh 9 x 9 multiply then yields lo=0x51.
